delay_line_ctrl: RTL

//  Sequencer for the 312x48 SRAM circular delay line (spike-delay buffer). Owns the

---
 rtl/delay_line_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/delay_line_ctrl.sv
// Sequencer for the 312x48 SRAM circular spike-delay buffer: power/wake control,
// zero-priming after wake or depth change, and write-data alignment to the strobe.
module delay_line_ctrl #(
    parameter int W         = 48,
    parameter int AW        = 9,
    parameter int WAKE_CYC  = 4,
    parameter int DEPTH_MAX = 311
) (
    input  logic          CLK,
    input  logic          RSTB,
    input  logic          i_en,
    input  logic [AW-1:0] i_cfg_depth,
    input  logic          i_cfg_upd,
    input  logic          i_s_valid,
    output logic          o_s_ready,
    input  logic [W-1:0]  i_s_data,
    output logic          o_m_valid,
    output logic [W-1:0]  o_m_data,
    output logic          o_busy,
    output logic          o_buf_pd,
    output logic          o_buf_in_valid,
    output logic [AW-1:0] o_buf_depth,
    output logic [W-1:0]  o_buf_d,
    input  logic [W-1:0]  i_buf_q
);

    localparam int WCW = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_WAKE,
        ST_PRIME,
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_depth_q;
    logic [AW-1:0]   r_shadow_ptr;
    logic [AW-1:0]   r_pcnt;
    logic [WCW-1:0]  r_wcnt;
    logic            r_reprime;
    logic            r_m_valid;
    logic [W-1:0]    r_buf_d;

    logic            w_strobe;
    logic            w_s_ready;
    logic            w_latch_depth;
    logic            w_set_reprime;
    logic            w_phase_a;
    logic            w_prime_last;
    logic [AW-1:0]   w_cfg_clamped;

    assign w_cfg_clamped = (i_cfg_depth > AW'(DEPTH_MAX)) ? AW'(DEPTH_MAX) : i_cfg_depth;

    // A pointer left beyond a shrunken depth must first run out to the AW-bit wrap.
    assign w_phase_a    = (r_shadow_ptr > r_depth_q);
    assign w_prime_last = !w_phase_a && (r_pcnt == r_depth_q);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_strobe      = 1'b0;
        w_s_ready     = 1'b0;
        w_latch_depth = 1'b0;
        w_set_reprime = 1'b0;
        case (r_state)
            ST_OFF: begin
                if (i_en) begin
                    w_state_next  = ST_WAKE;
                    w_latch_depth = 1'b1;
                end
            end
            ST_WAKE: begin
                if (!i_en) begin
                    w_state_next = ST_OFF;
                end else if (r_wcnt == WCW'(WAKE_CYC - 1)) begin
                    w_state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!i_en) begin
                    w_state_next = ST_FLUSH;
                end else begin
                    w_strobe = 1'b1;
                    if (w_prime_last) begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_s_ready = i_en & ~i_cfg_upd;
                w_strobe  = i_s_valid & w_s_ready;
                if (!i_en) begin
                    w_state_next = ST_FLUSH;
                end else if (i_cfg_upd) begin
                    w_state_next  = ST_FLUSH;
                    w_set_reprime = 1'b1;
                end
            end
            ST_FLUSH: begin
                // The write for the last strobe lands during this cycle.
                if (r_reprime && i_en) begin
                    w_state_next  = ST_PRIME;
                    w_latch_depth = 1'b1;
                end else begin
                    w_state_next = ST_OFF;
                end
            end
            default: begin
                w_state_next = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            r_depth_q    <= '0;
            r_shadow_ptr <= '0;
            r_pcnt       <= '0;
            r_wcnt       <= '0;
            r_reprime    <= 1'b0;
            r_m_valid    <= 1'b0;
            r_buf_d      <= '0;
        end else begin
            if (w_latch_depth) begin
                r_depth_q <= w_cfg_clamped;
            end

            if (r_state == ST_WAKE) begin
                r_wcnt <= r_wcnt + WCW'(1);
            end else begin
                r_wcnt <= '0;
            end

            if (r_state != ST_PRIME) begin
                r_pcnt <= '0;
            end else if (w_strobe && !w_phase_a) begin
                r_pcnt <= w_prime_last ? '0 : r_pcnt + AW'(1);
            end

            r_reprime <= w_set_reprime;

            if (w_strobe) begin
                r_shadow_ptr <= (r_shadow_ptr == r_depth_q) ? '0 : r_shadow_ptr + AW'(1);
                // Buffer captures D one cycle after the strobe.
                r_buf_d      <= (r_state == ST_RUN) ? i_s_data : '0;
            end

            r_m_valid <= w_strobe && (r_state == ST_RUN);
        end
    end

    assign o_s_ready      = w_s_ready;
    assign o_buf_in_valid = w_strobe;
    assign o_buf_pd       = (r_state == ST_OFF);
    assign o_busy         = (r_state == ST_WAKE) || (r_state == ST_PRIME) || (r_state == ST_FLUSH);
    assign o_buf_depth    = r_depth_q;
    assign o_buf_d        = r_buf_d;
    assign o_m_valid      = r_m_valid;
    assign o_m_data       = r_m_valid ? i_buf_q : '0;

endmodule
